// File: rtl/repeat_modulo_counter.sv
// Modulo time-field counter with run-time modulus, load, clamp, carry and
// built-in hold-to-repeat for the up/down set buttons.
module repeat_modulo_counter #(
   parameter int unsigned WIDTH         = 6,
   parameter int unsigned REPEAT_DELAY  = 8,
   parameter int unsigned REPEAT_PERIOD = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             count_up,
   input  logic             count_down,
   input  logic             wrap_en,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic [WIDTH-1:0] modulus,
   output logic [WIDTH-1:0] count,
   output logic             carry,
   output logic             step_pulse,
   output logic             repeating
);

   localparam int unsigned TMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
   localparam int unsigned TW   = (TMAX > 2) ? $clog2(TMAX) : 1;
   localparam logic [TW-1:0] DELAY_LAST  = TW'(REPEAT_DELAY - 1);
   localparam logic [TW-1:0] PERIOD_LAST = TW'(REPEAT_PERIOD - 1);

   typedef enum logic [1:0] {StIdle, StWait, StRepeat} state_e;

   state_e           state_q, state_d;
   logic [TW-1:0]    timer_q, timer_d;
   logic             dir_up_q, dir_up_d;
   logic             repeating_q;
   logic [WIDTH-1:0] count_q, count_d;
   logic             carry_q, carry_d;
   logic             step_pulse_q, step_pulse_d;
   logic             pending_q, pending_d;
   logic             pending_up_q, pending_up_d;

   logic             step_req;
   logic             step_up;
   logic             one_held;
   logic             keep;
   logic [WIDTH-1:0] n_eff;
   logic [WIDTH-1:0] n_last;
   logic             do_step;
   logic             do_up;

   // Moduli below 2 behave as 2.
   assign n_eff  = (modulus < WIDTH'(2)) ? WIDTH'(2) : modulus;
   assign n_last = n_eff - WIDTH'(1);

   assign one_held = count_up ^ count_down;
   assign keep     = (dir_up_q ? count_up : count_down) && !(count_up && count_down);

   always_comb begin
      state_d  = state_q;
      timer_d  = timer_q;
      dir_up_d = dir_up_q;
      step_req = 1'b0;
      step_up  = dir_up_q;
      unique case (state_q)
         StIdle: begin
            if (one_held) begin
               step_req = 1'b1;
               step_up  = count_up;
               dir_up_d = count_up;
               timer_d  = '0;
               state_d  = StWait;
            end
         end
         StWait: begin
            if (!keep) begin
               state_d = StIdle;
               timer_d = '0;
            end else if (timer_q == DELAY_LAST) begin
               step_req = 1'b1;
               timer_d  = '0;
               state_d  = StRepeat;
            end else begin
               timer_d = timer_q + TW'(1);
            end
         end
         StRepeat: begin
            if (!keep) begin
               state_d = StIdle;
               timer_d = '0;
            end else if (timer_q == PERIOD_LAST) begin
               step_req = 1'b1;
               timer_d  = '0;
            end else begin
               timer_d = timer_q + TW'(1);
            end
         end
         default: begin
            state_d = StIdle;
            timer_d = '0;
         end
      endcase
   end

   // A fresh request supersedes any older pending step.
   assign do_step = step_req | pending_q;
   assign do_up   = step_req ? step_up : pending_up_q;

   always_comb begin
      count_d      = count_q;
      carry_d      = 1'b0;
      step_pulse_d = 1'b0;
      pending_d    = pending_q;
      pending_up_d = pending_up_q;
      if (load) begin
         count_d = (load_val > n_last) ? n_last : load_val;
      end else if (count_q > n_last) begin
         count_d = n_last;
         if (step_req) begin
            pending_d    = 1'b1;
            pending_up_d = step_up;
         end
      end else if (en) begin
         if (count_q == n_last) begin
            count_d = '0;
            carry_d = 1'b1;
         end else begin
            count_d = count_q + WIDTH'(1);
         end
         if (step_req) begin
            pending_d    = 1'b1;
            pending_up_d = step_up;
         end
      end else if (do_step) begin
         pending_d    = 1'b0;
         step_pulse_d = 1'b1;
         if (do_up) begin
            if (count_q == n_last) count_d = wrap_en ? '0 : count_q;
            else                   count_d = count_q + WIDTH'(1);
         end else begin
            if (count_q == '0) count_d = wrap_en ? n_last : count_q;
            else               count_d = count_q - WIDTH'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= StIdle;
         timer_q      <= '0;
         dir_up_q     <= 1'b0;
         repeating_q  <= 1'b0;
         count_q      <= '0;
         carry_q      <= 1'b0;
         step_pulse_q <= 1'b0;
         pending_q    <= 1'b0;
         pending_up_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         timer_q      <= timer_d;
         dir_up_q     <= dir_up_d;
         repeating_q  <= (state_d == StRepeat);
         count_q      <= count_d;
         carry_q      <= carry_d;
         step_pulse_q <= step_pulse_d;
         pending_q    <= pending_d;
         pending_up_q <= pending_up_d;
      end
   end

   assign count      = count_q;
   assign carry      = carry_q;
   assign step_pulse = step_pulse_q;
   assign repeating  = repeating_q;

endmodule

// File: tb/tb_repeat_modulo_counter.sv
// Directed bench for repeat_modulo_counter with hand-computed expectations.
module tb_repeat_modulo_counter;

   logic       clk;
   logic       rst;
   logic       en;
   logic       count_up;
   logic       count_down;
   logic       wrap_en;
   logic       load;
   logic [5:0] load_val;
   logic [5:0] modulus;
   logic [5:0] count;
   logic       carry;
   logic       step_pulse;
   logic       repeating;

   int checks   = 0;
   int failures = 0;

   repeat_modulo_counter #(
      .WIDTH        (6),
      .REPEAT_DELAY (8),
      .REPEAT_PERIOD(4)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .en        (en),
      .count_up  (count_up),
      .count_down(count_down),
      .wrap_en   (wrap_en),
      .load      (load),
      .load_val  (load_val),
      .modulus   (modulus),
      .count     (count),
      .carry     (carry),
      .step_pulse(step_pulse),
      .repeating (repeating)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one active edge, then settle before sampling.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_load(input logic [5:0] v);
      load     = 1'b1;
      load_val = v;
      tick();
      load     = 1'b0;
   endtask

   task automatic test_reset();
      en = 1'b1; count_up = 1'b1; load = 1'b1; load_val = 6'd9; rst = 1'b1;
      tick();
      checks++;
      if (count !== 6'd0 || carry !== 1'b0 || step_pulse !== 1'b0 || repeating !== 1'b0) begin
         failures++;
         $display("FAIL reset got count=%0d carry=%b step=%b rep=%b exp 0/0/0/0",
                  count, carry, step_pulse, repeating);
      end
      en = 1'b0; count_up = 1'b0; load = 1'b0; rst = 1'b0;
      tick();
      checks++;
      if (count !== 6'd0 || step_pulse !== 1'b0) begin
         failures++;
         $display("FAIL reset_idle got count=%0d step=%b exp 0/0", count, step_pulse);
      end
   endtask

   task automatic test_wrap();
      logic [5:0] exp_c [3] = '{6'd59, 6'd0, 6'd1};
      logic       exp_k [3] = '{1'b0, 1'b1, 1'b0};
      modulus = 6'd60;
      do_load(6'd58);
      en = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++;
         if (count !== exp_c[i] || carry !== exp_k[i]) begin
            failures++;
            $display("FAIL wrap[%0d] got count=%0d carry=%b exp count=%0d carry=%b",
                     i, count, carry, exp_c[i], exp_k[i]);
         end
      end
      en = 1'b0;
      tick();
   endtask

   task automatic test_repeat();
      logic [5:0] exp_c;
      logic       exp_s;
      logic       exp_r;
      do_load(6'd10);
      count_up = 1'b1;
      for (int i = 0; i < 20; i++) begin
         tick();
         // Steps at offsets 0, 8, 12, 16 from the first press edge.
         exp_c = 6'd11 + 6'(i >= 8) + 6'(i >= 12) + 6'(i >= 16);
         exp_s = (i == 0) || (i == 8) || (i == 12) || (i == 16);
         exp_r = (i >= 8);
         checks++;
         if (count !== exp_c || step_pulse !== exp_s || repeating !== exp_r) begin
            failures++;
            $display("FAIL repeat[%0d] got count=%0d step=%b rep=%b exp %0d/%b/%b",
                     i, count, step_pulse, repeating, exp_c, exp_s, exp_r);
         end
      end
      count_up = 1'b0;
      tick();
      checks++;
      if (count !== 6'd14 || repeating !== 1'b0 || step_pulse !== 1'b0) begin
         failures++;
         $display("FAIL repeat_release got count=%0d rep=%b step=%b exp 14/0/0",
                  count, repeating, step_pulse);
      end
   endtask

   task automatic test_saturate();
      do_load(6'd0);
      wrap_en = 1'b0; count_down = 1'b1;
      tick();
      count_down = 1'b0;
      checks++;
      if (count !== 6'd0 || step_pulse !== 1'b1 || carry !== 1'b0) begin
         failures++;
         $display("FAIL sat_down got count=%0d step=%b carry=%b exp 0/1/0", count, step_pulse, carry);
      end
      tick();
      wrap_en = 1'b1; count_down = 1'b1;
      tick();
      count_down = 1'b0;
      checks++;
      if (count !== 6'd59 || step_pulse !== 1'b1 || carry !== 1'b0) begin
         failures++;
         $display("FAIL wrap_down got count=%0d step=%b carry=%b exp 59/1/0", count, step_pulse, carry);
      end
      tick();
      wrap_en = 1'b0; count_up = 1'b1;
      tick();
      count_up = 1'b0;
      checks++;
      if (count !== 6'd59 || step_pulse !== 1'b1) begin
         failures++;
         $display("FAIL sat_up got count=%0d step=%b exp 59/1", count, step_pulse);
      end
      tick();
      wrap_en = 1'b1; count_up = 1'b1;
      tick();
      count_up = 1'b0;
      checks++;
      if (count !== 6'd0 || step_pulse !== 1'b1 || carry !== 1'b0) begin
         failures++;
         $display("FAIL wrap_up got count=%0d step=%b carry=%b exp 0/1/0", count, step_pulse, carry);
      end
      tick();
   endtask

   task automatic test_collision();
      do_load(6'd20);
      en = 1'b1; count_up = 1'b1;
      tick();
      en = 1'b0;
      checks++;
      if (count !== 6'd21 || carry !== 1'b0 || step_pulse !== 1'b0) begin
         failures++;
         $display("FAIL collide_en got count=%0d carry=%b step=%b exp 21/0/0",
                  count, carry, step_pulse);
      end
      tick();
      checks++;
      if (count !== 6'd22 || step_pulse !== 1'b1 || carry !== 1'b0) begin
         failures++;
         $display("FAIL collide_pending got count=%0d step=%b carry=%b exp 22/1/0",
                  count, step_pulse, carry);
      end
      count_up = 1'b0;
      tick();
   endtask

   task automatic test_modulus_load();
      do_load(6'd30);
      modulus = 6'd24;
      tick();
      checks++;
      if (count !== 6'd23 || carry !== 1'b0) begin
         failures++;
         $display("FAIL clamp got count=%0d carry=%b exp 23/0", count, carry);
      end
      do_load(6'd40);
      checks++;
      if (count !== 6'd23) begin
         failures++;
         $display("FAIL load_sat got count=%0d exp 23", count);
      end
      count_down = 1'b1;
      do_load(6'd5);
      checks++;
      if (count !== 6'd5 || step_pulse !== 1'b0) begin
         failures++;
         $display("FAIL load_vs_press got count=%0d step=%b exp 5/0", count, step_pulse);
      end
      count_down = 1'b0;
      tick();
      checks++;
      if (count !== 6'd5 || step_pulse !== 1'b0) begin
         failures++;
         $display("FAIL press_lost got count=%0d step=%b exp 5/0", count, step_pulse);
      end
      count_up = 1'b1; count_down = 1'b1;
      tick();
      checks++;
      if (count !== 6'd5 || step_pulse !== 1'b0) begin
         failures++;
         $display("FAIL both_held got count=%0d step=%b exp 5/0", count, step_pulse);
      end
      count_up = 1'b0; count_down = 1'b0;
      modulus = 6'd0;
      tick();
      checks++;
      if (count !== 6'd1) begin
         failures++;
         $display("FAIL mod0_clamp got count=%0d exp 1", count);
      end
      en = 1'b1;
      tick();
      en = 1'b0;
      checks++;
      if (count !== 6'd0 || carry !== 1'b1) begin
         failures++;
         $display("FAIL mod0_wrap got count=%0d carry=%b exp 0/1", count, carry);
      end
      modulus = 6'd60;
      tick();
   endtask

   task automatic test_reset_mid_repeat();
      do_load(6'd5);
      count_up = 1'b1;
      for (int i = 0; i < 9; i++) tick();
      checks++;
      if (count !== 6'd7 || repeating !== 1'b1) begin
         failures++;
         $display("FAIL pre_rst got count=%0d rep=%b exp 7/1", count, repeating);
      end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      checks++;
      if (count !== 6'd0 || repeating !== 1'b0 || step_pulse !== 1'b0) begin
         failures++;
         $display("FAIL mid_rst got count=%0d rep=%b step=%b exp 0/0/0",
                  count, repeating, step_pulse);
      end
      tick();
      checks++;
      if (count !== 6'd1 || step_pulse !== 1'b1 || repeating !== 1'b0) begin
         failures++;
         $display("FAIL post_rst_step got count=%0d step=%b rep=%b exp 1/1/0",
                  count, step_pulse, repeating);
      end
      for (int i = 0; i < 7; i++) tick();
      checks++;
      if (count !== 6'd1 || repeating !== 1'b0) begin
         failures++;
         $display("FAIL post_rst_wait got count=%0d rep=%b exp 1/0", count, repeating);
      end
      tick();
      checks++;
      if (count !== 6'd2 || repeating !== 1'b1 || step_pulse !== 1'b1) begin
         failures++;
         $display("FAIL post_rst_second got count=%0d rep=%b step=%b exp 2/1/1",
                  count, repeating, step_pulse);
      end
      count_up = 1'b0;
      tick();
   endtask

   initial begin
      rst = 1'b0; en = 1'b0; count_up = 1'b0; count_down = 1'b0; wrap_en = 1'b0;
      load = 1'b0; load_val = 6'd0; modulus = 6'd60;
      test_reset();
      test_wrap();
      test_repeat();
      test_saturate();
      test_collision();
      test_modulus_load();
      test_reset_mid_repeat();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
